// File: rtl/clock_display_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame digit snapshot and blinking colon.
// Optional LEADING_ZERO_BLANK_EN: darken the hr_tens slot when its snapshot is 0.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] hr_tens,
  input  logic       blank,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             colon_q, colon_d;
  logic [3:0]       mo_q, mo_d, mt_q, mt_d, ho_q, ho_d, ht_q, ht_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       frame_end;
  logic       dark;
  logic [3:0] digit;
  logic [6:0] glyph;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    frame_end = tick && (idx_q == 2'd3);

    div_d   = tick ? '0 : div_q + DIV_W'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    frm_d   = frm_q;
    colon_d = colon_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    ho_d    = ho_q;
    ht_d    = ht_q;

    // All four digits captured on the same edge so a frame never shows a torn time.
    if (frame_end) begin
      mo_d = min_ones;
      mt_d = min_tens;
      ho_d = hr_ones;
      ht_d = hr_tens;
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        colon_d = ~colon_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    case (idx_q)
      2'd0:    digit = mo_q;
      2'd1:    digit = mt_q;
      2'd2:    digit = ho_q;
      default: digit = ht_q;
    endcase

    case (digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase

    dark = (div_q < GUARD_V) || blank;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == 2'd3) && (ht_q == 4'd0)) dark = 1'b1;
`else
`endif

    an_d  = dark ? '1 : ~(4'b0001 << idx_q);
    seg_d = dark ? '1 : glyph;
    dp_d  = ~(!dark && (idx_q == 2'd2) && colon_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      colon_q <= 1'b0;
      mo_q    <= '0;
      mt_q    <= '0;
      ho_q    <= '0;
      ht_q    <= '0;
      seg_q   <= '1;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      colon_q <= colon_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      ho_q    <= ho_d;
      ht_q    <= ht_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign dp_n  = dp_q;

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed four-digit seven-segment scanner for the oven time-of-day display. It reads the four BCD digits produced by the oven clock counter: minute ones, minute tens, hour ones and hour tens. It drives one shared active-low segment bus and four active-low digit anodes, plus a blinking colon on the decimal point. It sits between the clock counter and the board display pins. All four digits are snapshotted once per frame so the display never shows a torn time.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 ≤ GUARD < SCAN_DIV.
- BLINK_FRAMES, 250: full frames per colon toggle; legal range ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- min_ones  in  4  BCD minute units digit.
- min_tens  in  4  BCD minute tens digit.
- hr_ones  in  4  BCD hour units digit.
- hr_tens  in  4  BCD hour tens digit.
- blank  in  1  1 = all anodes off; scanning continues.
- seg_n  out  7  {g,f,e,d,c,b,a}, active low.
- an_n  out  4  digit anodes, active low: [0]=min_ones, [1]=min_tens, [2]=hr_ones, [3]=hr_tens.
- dp_n  out  1  colon / decimal point, active low; lit only in slot 2.

## Operation
- **State.** div_cnt (0..SCAN_DIV-1), idx (0..3), frame_cnt (0..BLINK_FRAMES-1), colon (1 bit), four 4-bit snapshot registers.
- **Tick.** A tick occurs on the cycle where div_cnt == SCAN_DIV-1. On a tick:
  - div_cnt ← 0.
  - idx ← idx+1, wrapping 3→0.
  - All other cycles: div_cnt increments.
- **Snapshot.** On a tick with idx == 3, all four digit inputs are captured into the snapshot registers at the same edge. Slot 0 of the new frame shows the new values.
- **Colon blink.** On a tick with idx == 3, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and colon toggles.
- **Segment decode.** Digits 0–9 use standard encoding:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
  - Values 10–15 display a dash, 7'h3F (segment g only).
- **Anode select.** an_n has the bit for idx low, the others high. an_n is 4'hF when div_cnt < GUARD or blank == 1.
- **Colon output.** dp_n = 0 only when idx == 2, colon == 1, and the anode is enabled. Otherwise dp_n = 1.
- **Segments while dark.** seg_n is 7'h7F whenever an_n == 4'hF.
- **Reset.** Asserting rst_n at any time, including mid-slot, forces immediately:
  - div_cnt = 0, idx = 0, frame_cnt = 0, colon = 0, snapshots = 0.
  - seg_n = 7'h7F, an_n = 4'hF, dp_n = 1.

## Timing
- All outputs are registered. Outputs at edge t+1 decode the state (div_cnt, idx, snapshots, colon, blank) present before edge t+1. This gives one-cycle latency relative to internal state.
- The first frame after reset displays zeros, because snapshots are 0. Live digits appear from the second frame: the first capture happens on the 4th tick, i.e. 4·SCAN_DIV cycles after reset release.
- Frame period is 4·SCAN_DIV cycles. Colon half-period is 4·SCAN_DIV·BLINK_FRAMES cycles.
- blank takes effect on outputs one cycle after it is sampled. It does not reset or pause any counter.
- Input changes outside the snapshot edge are ignored until the next frame boundary. An input change coinciding with the snapshot edge is captured.
- With GUARD = 0, anodes are never darkened between slots.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In slot 3, if the hr_tens snapshot == 0, an_n = 4'hF, seg_n = 7'h7F and dp_n = 1 for the whole slot.
  - Example: 09:30 shows as " 9:30".
- LEADING_ZERO_BLANK_EN undefined: slot 3 always displays the hr_tens snapshot, including 0 (7'h40).

## Test plan
All scenarios use SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2 unless noted.

- **Reset.** Hold rst_n=0 mid-slot → seg_n=7'h7F, an_n=4'hF, dp_n=1 immediately. After release, the first frame shows 7'h40 on each of an_n=4'hE, 4'hD, 4'hB, 4'h7, each with one guard cycle of 4'hF.
- **Snapshot.** Apply inputs 1,2,3,4 (min_ones..hr_tens) during frame 0, then change them to 9,9,9,9 mid-frame 1 → frame 1 shows 7'h79, 7'h24, 7'h30, 7'h19 on slots 0–3 (the digits captured at the frame-0 end); frame 2 shows 7'h10 everywhere.
- **Invalid BCD.** min_tens=4'hC → slot 1 shows seg_n=7'h3F.
- **Colon blink.** Observe 6 frames → dp_n=0 during the slot-2 lit cycles of frames 2–3, and 1 in frames 0–1 and 4–5.
- **Blank.** Assert blank for one full frame → an_n=4'hF and seg_n=7'h7F throughout that frame. After deassertion, the next slot resumes in the correct idx order with no reset of phase.
- **Leading zero.** With LEADING_ZERO_BLANK_EN defined and hr_tens=0 → slot 3 keeps an_n=4'hF. Without the macro, slot 3 shows an_n=4'h7, seg_n=7'h40.
